// File: rtl/traffic_light_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_conflict_monitor
// Purpose  : Safety stage between the light controller and lamp drivers; forces
//            flashing/solid all-red on illegal or conflicting commands.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_conflict_monitor #(
  parameter int FLASH_HALF  = 1,
  parameter int MIN_YELLOW  = 3,
  parameter int ALLRED_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] NS_light_in,
  input  logic [2:0] EW_light_in,
  input  logic       clear,
  output logic [2:0] NS_lamp,
  output logic [2:0] EW_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int FW = $clog2(FLASH_HALF) + 1;
  localparam int YW = $clog2(MIN_YELLOW) + 1;
  localparam int HW = $clog2(ALLRED_HOLD) + 1;

  localparam logic [2:0]    c_RED        = 3'b100;
  localparam logic [2:0]    c_YEL        = 3'b010;
  localparam logic [2:0]    c_GRN        = 3'b001;
  localparam logic [2:0]    c_OFF        = 3'b000;
  localparam logic [FW-1:0] c_FLASH_HALF = FW'(FLASH_HALF);
  localparam logic [FW-1:0] c_FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [YW-1:0] c_MIN_YELLOW = YW'(MIN_YELLOW);
  localparam logic [HW-1:0] c_HOLD       = HW'(ALLRED_HOLD);

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_ns_lamp;
  logic [2:0]    r_ew_lamp;
  logic          r_fault;
  logic [2:0]    r_code;
  logic [2:0]    r_prev_ns;
  logic [2:0]    r_prev_ew;
  logic [YW-1:0] r_ycnt_ns;
  logic [YW-1:0] r_ycnt_ew;
  logic [FW-1:0] r_flash_cnt;
  logic [HW-1:0] r_hold_cnt;

  logic          w_ns_oh;
  logic          w_ew_oh;
  logic          w_ns_short;
  logic          w_ew_short;
  logic [2:0]    w_code;
  logic [FW-1:0] w_flash_nxt;
  logic [YW-1:0] w_ycnt_ns_nxt;
  logic [YW-1:0] w_ycnt_ew_nxt;
  logic          w_rearm_ok;

  function automatic logic f_onehot(input logic [2:0] v);
    return (v == c_RED) || (v == c_YEL) || (v == c_GRN);
  endfunction

  // Legal moves: hold, G->Y, Y->R, R->G.
  function automatic logic f_legal(input logic [2:0] prev, input logic [2:0] cur);
    return (cur == prev) ||
           ((prev == c_GRN) && (cur == c_YEL)) ||
           ((prev == c_YEL) && (cur == c_RED)) ||
           ((prev == c_RED) && (cur == c_GRN));
  endfunction

  function automatic logic [YW-1:0] f_ycnt(input logic [2:0] cur, input logic [YW-1:0] cnt);
    if (cur != c_YEL)        return '0;
    if (cnt == c_MIN_YELLOW) return cnt;
    return cnt + YW'(1);
  endfunction

  always_comb begin
    w_ns_oh       = f_onehot(NS_light_in);
    w_ew_oh       = f_onehot(EW_light_in);
    w_ns_short    = (r_prev_ns == c_YEL) && (NS_light_in == c_RED) && (r_ycnt_ns < c_MIN_YELLOW);
    w_ew_short    = (r_prev_ew == c_YEL) && (EW_light_in == c_RED) && (r_ycnt_ew < c_MIN_YELLOW);
    w_flash_nxt   = (r_flash_cnt == c_FLASH_LAST) ? '0 : r_flash_cnt + FW'(1);
    w_ycnt_ns_nxt = f_ycnt(NS_light_in, r_ycnt_ns);
    w_ycnt_ew_nxt = f_ycnt(EW_light_in, r_ycnt_ew);
    w_rearm_ok    = w_ns_oh && w_ew_oh && (NS_light_in[2] || EW_light_in[2]);
    w_code        = 3'd0;
    if (!(w_ns_oh && w_ew_oh)) begin
      w_code = 3'd1;
    end else if (!NS_light_in[2] && !EW_light_in[2]) begin
      w_code = 3'd2;
    end else if (!f_legal(r_prev_ns, NS_light_in) || !f_legal(r_prev_ew, EW_light_in)) begin
      w_code = 3'd3;
    end else if (w_ns_short || w_ew_short) begin
      w_code = 3'd4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= MONITOR;
      r_ns_lamp   <= c_RED;
      r_ew_lamp   <= c_RED;
      r_fault     <= 1'b0;
      r_code      <= 3'd0;
      r_prev_ns   <= c_RED;
      r_prev_ew   <= c_RED;
      r_ycnt_ns   <= '0;
      r_ycnt_ew   <= '0;
      r_flash_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      case (r_state)
        MONITOR: begin
          if (w_code != 3'd0) begin
            // The offending command is never driven; flashing starts "on".
            r_state     <= FAULT;
            r_fault     <= 1'b1;
            r_code      <= w_code;
            r_ns_lamp   <= c_RED;
            r_ew_lamp   <= c_RED;
            r_flash_cnt <= '0;
          end else begin
            r_ns_lamp <= NS_light_in;
            r_ew_lamp <= EW_light_in;
            r_prev_ns <= NS_light_in;
            r_prev_ew <= EW_light_in;
            r_ycnt_ns <= w_ycnt_ns_nxt;
            r_ycnt_ew <= w_ycnt_ew_nxt;
          end
        end
        FAULT: begin
          if (clear) begin
            r_state    <= RECOVER;
            r_fault    <= 1'b0;
            r_ns_lamp  <= c_RED;
            r_ew_lamp  <= c_RED;
            r_hold_cnt <= '0;
          end else begin
            r_flash_cnt <= w_flash_nxt;
            r_ns_lamp   <= (w_flash_nxt < c_FLASH_HALF) ? c_RED : c_OFF;
            r_ew_lamp   <= (w_flash_nxt < c_FLASH_HALF) ? c_RED : c_OFF;
          end
        end
        RECOVER: begin
          r_ns_lamp <= c_RED;
          r_ew_lamp <= c_RED;
          if (r_hold_cnt != c_HOLD) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end else if (w_rearm_ok) begin
            r_state   <= MONITOR;
            r_code    <= 3'd0;
            r_prev_ns <= NS_light_in;
            r_prev_ew <= EW_light_in;
            r_ycnt_ns <= '0;
            r_ycnt_ew <= '0;
          end
        end
        default: r_state <= MONITOR;
      endcase
    end
  end

  assign NS_lamp    = r_ns_lamp;
  assign EW_lamp    = r_ew_lamp;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_conflict_monitor
// Purpose  : Directed + randomized bench against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_conflict_monitor;

  localparam int FH = 2;
  localparam int MY = 3;
  localparam int AH = 4;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] NS_light_in = R;
  logic [2:0] EW_light_in = R;
  logic       clear = 1'b0;
  logic [2:0] NS_lamp;
  logic [2:0] EW_lamp;
  logic       fault;
  logic [2:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_conflict_monitor #(
    .FLASH_HALF (FH),
    .MIN_YELLOW (MY),
    .ALLRED_HOLD(AH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .NS_light_in(NS_light_in),
    .EW_light_in(EW_light_in),
    .clear      (clear),
    .NS_lamp    (NS_lamp),
    .EW_lamp    (EW_lamp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 CLK = ~CLK;

  // Reference model: mode 0=monitor, 1=fault, 2=recover.
  int         m_mode;
  logic [2:0] m_ns, m_ew, m_code, p_ns, p_ew;
  logic       m_fault;
  int         yrun_ns, yrun_ew, fk, rk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      G:       return Y;
      Y:       return R;
      R:       return G;
      default: return 3'bxxx;
    endcase
  endfunction

  function automatic int rule_code(input logic [2:0] ns, input logic [2:0] ew);
    if ($countones(ns) != 1 || $countones(ew) != 1)                   return 1;
    if (ns != R && ew != R)                                           return 2;
    if (!(ns == p_ns || ns == succ(p_ns)) || !(ew == p_ew || ew == succ(p_ew))) return 3;
    if ((p_ns == Y && ns == R && yrun_ns < MY) || (p_ew == Y && ew == R && yrun_ew < MY)) return 4;
    return 0;
  endfunction

  task automatic model_edge(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic rs);
    int c;
    if (rs) begin
      m_mode = 0; m_ns = R; m_ew = R; m_fault = 0; m_code = 0;
      p_ns = R; p_ew = R; yrun_ns = 0; yrun_ew = 0; fk = 0; rk = 0;
    end else if (m_mode == 0) begin
      c = rule_code(ns, ew);
      if (c != 0) begin
        m_mode = 1; m_fault = 1; m_code = 3'(c); m_ns = R; m_ew = R; fk = 0;
      end else begin
        m_ns = ns; m_ew = ew;
        yrun_ns = (ns == Y) ? yrun_ns + 1 : 0;
        yrun_ew = (ew == Y) ? yrun_ew + 1 : 0;
        p_ns = ns; p_ew = ew;
      end
    end else if (m_mode == 1) begin
      if (clr) begin
        m_mode = 2; m_fault = 0; m_ns = R; m_ew = R; rk = 0;
      end else begin
        fk++;
        m_ns = (((fk / FH) % 2) == 0) ? R : 3'b000;
        m_ew = m_ns;
      end
    end else begin
      rk++;
      m_ns = R; m_ew = R;
      if (rk > AH && $countones(ns) == 1 && $countones(ew) == 1 && (ns == R || ew == R)) begin
        m_mode = 0; m_code = 0; p_ns = ns; p_ew = ew; yrun_ns = 0; yrun_ew = 0;
      end
    end
  endtask

  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic rs);
    NS_light_in = ns; EW_light_in = ew; clear = clr; RST = rs;
    @(posedge CLK);
    model_edge(ns, ew, clr, rs);
    #1;
    chk("ns_lamp", 32'(NS_lamp), 32'(m_ns));
    chk("ew_lamp", 32'(EW_lamp), 32'(m_ew));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_code", 32'(fault_code), 32'(m_code));
  endtask

  task automatic recover();
    step(R, R, 1'b1, 1'b0);
    for (int i = 0; i < AH + 1; i++) step(R, R, 1'b0, 1'b0);
  endtask

  task automatic rep(input logic [2:0] ns, input logic [2:0] ew, input int n);
    for (int i = 0; i < n; i++) step(ns, ew, 1'b0, 1'b0);
  endtask

  initial begin
    int ph, left;
    logic [2:0] cn, ce;

    step(R, R, 1'b0, 1'b1);
    step(R, R, 1'b0, 1'b1);
    chk("rst_code", 32'(fault_code), 32'd0);

    // Full legal controller cycle, three times.
    for (int k = 0; k < 3; k++) begin
      rep(G, R, 11); rep(Y, R, 4); rep(R, R, 11);
      rep(R, G, 11); rep(R, Y, 4); rep(R, R, 11);
    end
    chk("legal_fault", 32'(fault), 32'd0);

    // Conflict, then watch the flash pattern.
    step(G, G, 1'b0, 1'b0);
    chk("conflict_code", 32'(fault_code), 32'd2);
    rep(R, R, 8);
    recover();

    // G->R illegal; short yellow; full-length yellow.
    step(G, R, 1'b0, 1'b0);
    step(R, R, 1'b0, 1'b0);
    chk("illegal_code", 32'(fault_code), 32'd3);
    recover();
    step(G, R, 1'b0, 1'b0); rep(Y, R, 2); step(R, R, 1'b0, 1'b0);
    chk("short_y_code", 32'(fault_code), 32'd4);
    recover();
    step(G, R, 1'b0, 1'b0); rep(Y, R, 3); step(R, R, 1'b0, 1'b0);
    chk("full_y_fault", 32'(fault), 32'd0);

    // Invalid beats conflict; hold period keeps the code.
    step(3'b011, G, 1'b0, 1'b0);
    chk("invalid_code", 32'(fault_code), 32'd1);
    step(R, R, 1'b1, 1'b0);
    for (int i = 0; i < AH; i++) begin
      step(R, R, 1'b0, 1'b0);
      chk("hold_code", 32'(fault_code), 32'd1);
    end
    step(R, R, 1'b0, 1'b0);
    chk("rearm_code", 32'(fault_code), 32'd0);
    step(G, R, 1'b0, 1'b0);
    chk("track_ns", 32'(NS_lamp), 32'(G));

    // Clear held through invalid inputs in RECOVER.
    step(3'b000, R, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(3'b000, 3'b000, 1'b1, 1'b0);
    step(R, R, 1'b1, 1'b0);
    step(R, G, 1'b1, 1'b0);
    chk("rearm_track", 32'(EW_lamp), 32'(G));

    // Reset during the dark half of the flash; clear in MONITOR is inert.
    step(G, G, 1'b0, 1'b0);
    for (int i = 0; i < 10 && NS_lamp !== 3'b000; i++) step(R, R, 1'b0, 1'b0);
    chk("flash_off", 32'(NS_lamp), 32'd0);
    step(R, R, 1'b0, 1'b1);
    chk("rst_fault", 32'(fault), 32'd0);
    step(G, R, 1'b1, 1'b0);
    step(G, R, 1'b1, 1'b0);
    chk("clr_ignored", 32'(fault), 32'd0);

    // Randomized controller with short yellows, corrupted commands, clears, resets.
    ph = 0; left = 5;
    for (int i = 0; i < 2500; i++) begin
      case (ph)
        0: begin cn = G; ce = R; end
        1: begin cn = Y; ce = R; end
        3: begin cn = R; ce = G; end
        4: begin cn = R; ce = Y; end
        default: begin cn = R; ce = R; end
      endcase
      if ($urandom_range(99) < 4) begin
        cn = 3'($urandom);
        ce = 3'($urandom);
      end
      step(cn, ce, 1'($urandom_range(99) < 10), 1'($urandom_range(199) == 0));
      left--;
      if (left <= 0) begin
        ph = (ph + 1) % 6;
        left = (ph == 1 || ph == 4) ? int'($urandom_range(5, 1)) : int'($urandom_range(12, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
